// File: rtl/alu_issue_ctrl.sv
// Issue controller: registers one request into an external combinational ALU, captures its result and holds it as a response.
// Optional sticky flag accumulator is enabled by defining ALU_ISSUE_STICKY_FLAGS_EN.
module alu_issue_ctrl #(
    parameter int BUS   = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [BUS-1:0]   req_a_i,
    input  logic [BUS-1:0]   req_b_i,
    input  logic [2:0]       req_op_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [BUS-1:0]   alu_a_o,
    output logic [BUS-1:0]   alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [BUS-1:0]   alu_result_i,
    input  logic [3:0]       alu_flags_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [BUS-1:0]   rsp_result_o,
    output logic [3:0]       rsp_flags_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o,
    output logic [15:0]      op_count_o
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    ,
    input  logic             sticky_clr_i,
    output logic [3:0]       sticky_flags_o
`endif
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready_o high
    // EXEC  | operands on the ALU bus for one cycle, result captured at its end
    // RESP  | response held until rsp_ready_i; may accept the next request in the same cycle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             rsp_hs;

    // Ready is gated by reset so nothing is accepted while rst_ni is held low.
    assign req_ready_o = rst_ni && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;
    assign busy_o      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = req_valid_i ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_a_o  <= '0;
            alu_b_o  <= '0;
            alu_op_o <= 3'b000;
            tag_q    <= '0;
        end else if (accept) begin
            alu_a_o  <= req_a_i;
            alu_b_o  <= req_b_i;
            alu_op_o <= req_op_i;
            tag_q    <= req_tag_i;
        end
    end

    // The tag moves to the response only at the end of EXEC, so a back-to-back
    // accept in RESP cannot disturb the payload being handed over.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_result_o <= '0;
            rsp_flags_o  <= 4'b0000;
            rsp_tag_o    <= '0;
        end else if (state_q == ST_EXEC) begin
            rsp_result_o <= alu_result_i;
            rsp_flags_o  <= alu_flags_i;
            rsp_tag_o    <= tag_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_count_o <= 16'h0000;
        end else if (rsp_hs) begin
            op_count_o <= op_count_o + 16'd1;
        end
    end

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_flags_o <= 4'b0000;
        end else if (sticky_clr_i) begin
            sticky_flags_o <= 4'b0000;
        end else if (rsp_hs) begin
            sticky_flags_o <= sticky_flags_o | rsp_flags_o;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with an environment ALU and an arithmetic reference model.
// Define ALU_ISSUE_STICKY_FLAGS_EN to also exercise the sticky flag accumulator.
module tb_alu_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = 8'd0;
    logic [7:0]  req_b = 8'd0;
    logic [2:0]  req_op = 3'd0;
    logic [3:0]  req_tag = 4'd0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [15:0] op_count;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    logic        sticky_clr = 1'b0;
    logic [3:0]  sticky_flags;
    logic [3:0]  sticky_m = 4'd0;
`endif

    alu_issue_ctrl #(.BUS(8), .TAG_W(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .req_tag_i    (req_tag),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .alu_flags_i  (alu_flags),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_flags_o  (rsp_flags),
        .rsp_tag_o    (rsp_tag),
        .busy_o       (busy),
        .op_count_o   (op_count)
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        ,
        .sticky_clr_i   (sticky_clr),
        .sticky_flags_o (sticky_flags)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
        logic [3:0] tag;
        int         acc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic        gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment ALU: a + (b or ~b) + sub with carry out of the adder.
    logic [8:0] sum9;
    logic [7:0] bb;
    always_comb begin
        bb         = alu_op[0] ? ~alu_b : alu_b;
        sum9       = {1'b0, alu_a} + {1'b0, bb} + {8'd0, alu_op[0]};
        alu_result = 8'd0;
        alu_flags  = 4'd0;
        if (!alu_op[2]) begin
            alu_result   = sum9[7:0];
            alu_flags[3] = (alu_a[7] == bb[7]) && (sum9[7] != alu_a[7]);
            alu_flags[2] = sum9[8];
        end else if (!alu_op[1]) begin
            alu_result = alu_a & alu_b;
        end else begin
            alu_result = alu_a | alu_b;
        end
        alu_flags[1] = alu_result[7];
        alu_flags[0] = (alu_result == 8'd0);
    end

    // Reference model from integer arithmetic: returns {V,C,N,Z,result}.
    function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int ua, ub, sa, sb, r, sr;
        logic v, c;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        v = 1'b0;
        c = 1'b0;
        if (op[2] == 1'b0) begin
            if (op[0]) begin
                r  = ua - ub;
                sr = sa - sb;
                c  = (ua >= ub);
            end else begin
                r  = ua + ub;
                sr = sa + sb;
                c  = (r > 255);
            end
            v   = (sr > 127) || (sr < -128);
            res = r[7:0];
        end else if (op[1] == 1'b0) begin
            res = a & b;
        end else begin
            res = a | b;
        end
        return {v, c, res[7], (res == 8'd0), res};
    endfunction

    always @(posedge clk_i) cyc++;

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Issue tracker: records each accept into the scoreboard and checks the ALU drive holds.
    logic [7:0] last_a = 8'd0;
    logic [7:0] last_b = 8'd0;
    logic [2:0] last_op = 3'd0;
    always @(negedge clk_i) begin
        logic [11:0] m;
        exp_t e;
        if (!rst_ni) begin
            last_a  = 8'd0;
            last_b  = 8'd0;
            last_op = 3'd0;
            chk("alu_drive_rst", {alu_a, alu_b, alu_op}, 19'd0);
        end else begin
            chk("alu_drive_hold", {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
            if (req_valid && req_ready) begin
                m     = ref_alu(req_a, req_b, req_op);
                e.res = m[7:0];
                e.flg = m[11:8];
                e.tag = req_tag;
                e.acc = cyc;
                sb_q.push_back(e);
                last_a  = req_a;
                last_b  = req_b;
                last_op = req_op;
            end
        end
    end

    // Monitor: pops on every response handshake and checks payload, latency, stability, counters.
    logic        prev_stall = 1'b0;
    int          first_cyc = 0;
    logic [15:0] model_cnt = 16'd0;
    logic [15:0] held;
    logic        have_prev_hs = 1'b0;
    int          prev_hs_cyc = 0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!gap_chk) have_prev_hs = 1'b0;
        if (!rst_ni) begin
            sb_q.delete();
            model_cnt  = 16'd0;
            prev_stall = 1'b0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
            sticky_m = 4'd0;
            chk("rst_sticky", sticky_flags, 0);
`endif
        end else begin
            chk("op_count", op_count, model_cnt);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
            chk("sticky_flags", sticky_flags, sticky_m);
`endif
            if (rsp_valid) begin
                chk("busy_in_resp", busy, 1);
                if (!prev_stall) first_cyc = cyc;
                else chk("stall_stable", {rsp_result, rsp_flags, rsp_tag}, held);
                if (!rsp_ready) chk("stall_req_ready", req_ready, 0);
                if (rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_flags", rsp_flags, e.flg);
                        chk("rsp_tag", rsp_tag, e.tag);
                        chk("latency", first_cyc - e.acc, 2);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
                        if (!sticky_clr) sticky_m = sticky_m | rsp_flags;
`endif
                    end
                    model_cnt = model_cnt + 16'd1;
                    if (gap_chk) begin
                        if (have_prev_hs) chk("b2b_gap", cyc - prev_hs_cyc, 2);
                        have_prev_hs = 1'b1;
                        prev_hs_cyc  = cyc;
                    end
                end
            end
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
            if (sticky_clr) sticky_m = 4'd0;
`endif
            held       = {rsp_result, rsp_flags, rsp_tag};
            prev_stall = rsp_valid && !rsp_ready;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [3:0] tag);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (req_ready) begin
                @(posedge clk_i);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i);
            if (rsp_valid) return;
        end
        chk("rsp_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() == 0) return;
        end
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ready_low", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_payload", {rsp_result, rsp_flags, rsp_tag}, 16'd0);
        chk("reset_op_count", op_count, 0);
        rst_ni = 1'b1;

        // ADD overflow into sign bit; first accept right after reset release
        send(8'h7F, 8'h01, 3'b000, 4'h1);
        wait_rsp();
        chk("add_result", rsp_result, 8'h80);
        chk("add_flags", rsp_flags, 4'b1010);
        @(posedge clk_i);
        #1;

        send(8'h05, 8'h05, 3'b001, 4'h9);
        wait_rsp();
        chk("sub_result", rsp_result, 8'h00);
        chk("sub_flags", rsp_flags, 4'b0101);
        chk("sub_tag", rsp_tag, 4'h9);
        @(posedge clk_i);
        #1;

        // AND with the consumer stalled for five cycles
        rdy_mode = 2;
        send(8'hF0, 8'h0F, 3'b100, 4'h3);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_payload", {rsp_result, rsp_flags}, {8'h00, 4'b0001});
            chk("stall_ready_low", req_ready, 0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        rdy_mode = 0;
        drain();
        @(posedge clk_i);
        #1;

        gap_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'(i));
        end
        drain();
        gap_chk = 1'b0;
        chk("b2b_op_count", op_count, 16'd13);

        // Reset while the op is in EXEC
        send(8'h11, 8'h22, 3'b000, 4'hA);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("midrst_op_count", op_count, 0);
        repeat (4) @(posedge clk_i);
        #1;
        chk("midrst_no_rsp", rsp_valid, 0);
        send(8'h03, 8'h04, 3'b000, 4'h5);
        wait_rsp();
        chk("post_rst_result", rsp_result, 8'h07);
        chk("post_rst_tag", rsp_tag, 4'h5);
        @(posedge clk_i);
        #1;

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        send(8'h80, 8'h00, 3'b110, 4'h1);
        wait_rsp();
        @(posedge clk_i);
        #1;
        send(8'hFF, 8'h01, 3'b000, 4'h2);
        wait_rsp();
        @(posedge clk_i);
        #1;
        chk("sticky_accum", sticky_flags, 4'b0111);
        sticky_clr = 1'b1;
        @(posedge clk_i);
        #1;
        sticky_clr = 1'b0;
        chk("sticky_clear", sticky_flags, 4'b0000);
`endif

        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk_i);
                #1;
            end
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk_i);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
